network_source_deser: RTL and testbench

NETWORK_SOURCE_DESER -- requirements
Module: network_source_deser

---
 rtl/network_source_deser_pkg.sv | 28 ++
 rtl/network_source_deser_fifo.sv | 55 +++++
 rtl/network_source_deser.sv | 129 ++++++++++++
 tb/tb_network_source_deser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/network_source_deser_pkg.sv
// Shared configuration for the source deserializer: network shape, stream flag
// positions and the derived packet layout.
package network_config;
    localparam int NUM_INP      = 2;
    localparam int CHARGE_WIDTH = 8;
endpackage

package stream_config;
    localparam int NUM_FLG = 2;
    localparam int FIN     = 0;
    localparam int CLR     = 1;
endpackage

package source_config;
    import network_config::*;
    import stream_config::*;

    localparam int PFX_WIDTH = NUM_FLG;
    localparam int SPK_WIDTH = NUM_INP * CHARGE_WIDTH;
    localparam int PKT_WIDTH = PFX_WIDTH + SPK_WIDTH;

    typedef logic [PKT_WIDTH-1:0] pkt_t;

    // Number of source beats needed to carry one packet, rounded up.
    function automatic int beat_count(input int src_width);
        return (PKT_WIDTH + src_width - 1) / src_width;
    endfunction
endpackage

// File: rtl/network_source_deser_fifo.sv
// Synchronous packet FIFO with a combinational head read and occupancy count.
module packet_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     fill
);
    localparam int PTR_WIDTH  = $clog2(DEPTH);
    localparam int FILL_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_reg;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg;
    logic [FILL_WIDTH-1:0] fill_reg;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (fill_reg == FILL_WIDTH'(DEPTH));
    assign empty    = (fill_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];
    assign fill     = fill_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill_reg <= fill_reg + 1'b1;
                2'b01:   fill_reg <= fill_reg - 1'b1;
                default: fill_reg <= fill_reg;
            endcase
        end
    end
endmodule

// File: rtl/network_source_deser.sv
// Deserializes narrow source beats into packets, buffers them and presents them to
// the network. Optional macro NET_HALF_CLK_RST_EN selects a half-cycle network reset pulse.
module network_source_deser
    import network_config::*;
    import stream_config::*;
    import source_config::*;
#(
    parameter int SRC_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                arstn,
    input  logic                                src_valid,
    output logic                                src_ready,
    input  logic [SRC_WIDTH-1:0]                src,
    input  logic                                net_ready,
    output logic                                net_valid,
    output logic                                net_last,
    output logic                                net_arstn,
    output logic signed [CHARGE_WIDTH-1:0]      inp [NUM_INP],
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill
);
    localparam int BEATS     = beat_count(SRC_WIDTH);
    localparam int ASM_WIDTH = BEATS * SRC_WIDTH;
    localparam int HIST_W    = (BEATS > 1) ? (BEATS - 1) * SRC_WIDTH : 1;
    localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

    logic [CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
    logic [HIST_W-1:0]    asm_reg, asm_next;
    logic [ASM_WIDTH-1:0] beat_word;
    pkt_t                 push_pkt, head_pkt;
    logic                 final_beat, beat_fire, push, pop, full, empty;
    logic                 head_ok, rst_p;

    assign final_beat = (beat_cnt_reg == LAST_BEAT);
    assign src_ready  = !final_beat || !full;
    assign beat_fire  = src_valid && src_ready;
    assign push       = beat_fire && final_beat;
    assign push_pkt   = beat_word[ASM_WIDTH-1 -: PKT_WIDTH];

    // Earlier beats sit above the current one; the first beat ends up most significant.
    generate
        if (BEATS > 1) begin : g_multi
            assign beat_word = {asm_reg, src};
        end else begin : g_single
            logic unused_asm;
            assign beat_word  = src;
            assign unused_asm = ^asm_reg;
        end
        if (ASM_WIDTH > PKT_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^beat_word[ASM_WIDTH-PKT_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        asm_next      = asm_reg;
        if (beat_fire) begin
            if (final_beat) begin
                beat_cnt_next = '0;
                asm_next      = '0;
            end else begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
                asm_next      = beat_word[HIST_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt_reg <= '0;
            asm_reg      <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            asm_reg      <= asm_next;
        end
    end

    packet_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .push      (push),
        .push_data (push_pkt),
        .pop       (pop),
        .pop_data  (head_pkt),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );

    assign rst_p = pop && head_pkt[PKT_WIDTH-PFX_WIDTH+CLR];

`ifdef NET_HALF_CLK_RST_EN
    // Low-phase copy of rst_p lets the pulse cover only the high phase of its cycle.
    logic rst_neg_reg;
    always_ff @(negedge clk or negedge arstn) begin
        if (!arstn) rst_neg_reg <= 1'b0;
        else        rst_neg_reg <= rst_p;
    end
    assign head_ok   = !empty;
    assign net_arstn = arstn && !(rst_p && !rst_neg_reg);
`else
    // Full-cycle pulse; the head is held back while the network is in reset.
    logic rst_pos_reg;
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) rst_pos_reg <= 1'b0;
        else        rst_pos_reg <= rst_p;
    end
    assign head_ok   = !empty && !rst_pos_reg;
    assign net_arstn = arstn && !rst_pos_reg;
`endif

    assign net_valid = head_ok;
    assign pop       = head_ok && net_ready;
    assign net_last  = head_ok && head_pkt[PKT_WIDTH-PFX_WIDTH+FIN];

    generate
        for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_inp
            assign inp[gi] = head_ok
                ? signed'(head_pkt[SPK_WIDTH-1-gi*CHARGE_WIDTH -: CHARGE_WIDTH])
                : '0;
        end
    endgenerate
endmodule

// File: tb/tb_network_source_deser.sv
// Directed self-checking bench for network_source_deser (default parameters).
module tb_network_source_deser;
    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [7:0]        src = 8'h00;
    logic              net_ready = 1'b0;
    logic              net_valid;
    logic              net_last;
    logic              net_arstn;
    logic signed [7:0] inp [2];
    logic [2:0]        fill;

    int checks = 0;
    int errors = 0;

    logic [1:0]  ef [5];
    logic [7:0]  ea [5];
    logic [7:0]  eb [5];

    network_source_deser #(.SRC_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src       (src),
        .net_ready (net_ready),
        .net_valid (net_valid),
        .net_last  (net_last),
        .net_arstn (net_arstn),
        .inp       (inp),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk(input logic [1:0] f, input logic [7:0] a,
                                       input logic [7:0] b);
        return {f, a, b, 6'b000000};
    endfunction

    task automatic check_head(input string tag, input logic v, input logic l,
                              input logic [7:0] a, input logic [7:0] b);
        chk({tag, "_valid"}, 8'(net_valid), 8'(v));
        chk({tag, "_last"},  8'(net_last),  8'(l));
        chk({tag, "_inp0"},  8'(inp[0]),    a);
        chk({tag, "_inp1"},  8'(inp[1]),    b);
    endtask

    task automatic send_pkt(input logic [23:0] w);
        for (int b = 0; b < 3; b++) begin
            src_valid = 1'b1;
            src       = w[23-8*b -: 8];
            #1;
            chk("src_ready_beat", 8'(src_ready), 8'd1);
            tick();
        end
        src_valid = 1'b0;
    endtask

    initial begin
        logic [23:0] w;
        logic [7:0]  a;

        // Reset state
        #2;
        check_head("rst", 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_src_ready", 8'(src_ready), 8'd1);
        chk("rst_net_arstn", 8'(net_arstn), 8'd0);
        chk("rst_fill", 8'(fill), 8'd0);
        tick();
        tick();
        arstn = 1'b1;
        #1;
        chk("rel_net_arstn", 8'(net_arstn), 8'd1);

        // CLR packet followed by a FIN packet
        net_ready = 1'b0;
        send_pkt(24'h8040C0);
        #1;
        check_head("p1", 1'b1, 1'b0, 8'h01, 8'h03);
        chk("p1_fill", 8'(fill), 8'd1);
        chk("p1_net_arstn_idle", 8'(net_arstn), 8'd1);
        send_pkt(24'h40FFC0);
        #1;
        chk("p12_fill", 8'(fill), 8'd2);
        check_head("p1_hold", 1'b1, 1'b0, 8'h01, 8'h03);
        net_ready = 1'b1;
        #1;
`ifdef NET_HALF_CLK_RST_EN
        chk("clr_high_phase_arstn", 8'(net_arstn), 8'd0);
        @(negedge clk);
        #1;
        chk("clr_low_phase_arstn", 8'(net_arstn), 8'd1);
        tick();
        #1;
        check_head("p2", 1'b1, 1'b1, 8'h03, 8'hFF);
        chk("p2_net_arstn", 8'(net_arstn), 8'd1);
        chk("p2_fill", 8'(fill), 8'd1);
`else
        chk("clr_same_cycle_arstn", 8'(net_arstn), 8'd1);
        tick();
        #1;
        chk("clr_next_cycle_arstn", 8'(net_arstn), 8'd0);
        check_head("bubble", 1'b0, 1'b0, 8'h00, 8'h00);
        chk("bubble_fill", 8'(fill), 8'd1);
        tick();
        #1;
        check_head("p2", 1'b1, 1'b1, 8'h03, 8'hFF);
        chk("p2_net_arstn", 8'(net_arstn), 8'd1);
`endif
        tick();
        net_ready = 1'b0;
        #1;
        chk("drain_fill", 8'(fill), 8'd0);
        chk("drain_valid", 8'(net_valid), 8'd0);

        // Backpressure: fill the buffer, hold the fifth final beat
        ef[0] = 2'b00; ea[0] = 8'h11; eb[0] = 8'h22;
        ef[1] = 2'b01; ea[1] = 8'h33; eb[1] = 8'h44;
        ef[2] = 2'b00; ea[2] = 8'h55; eb[2] = 8'h66;
        ef[3] = 2'b01; ea[3] = 8'hFF; eb[3] = 8'h03;
        ef[4] = 2'b00; ea[4] = 8'h77; eb[4] = 8'h88;
        for (int k = 0; k < 4; k++) begin
            send_pkt(mk(ef[k], ea[k], eb[k]));
        end
        #1;
        chk("full_fill", 8'(fill), 8'd4);
        w = mk(ef[4], ea[4], eb[4]);
        src_valid = 1'b1;
        src = w[23:16];
        tick();
        src = w[15:8];
        tick();
        src = w[7:0];
        #1;
        chk("full_src_ready", 8'(src_ready), 8'd0);
        tick();
        chk("held_src_ready", 8'(src_ready), 8'd0);
        chk("held_fill", 8'(fill), 8'd4);
        net_ready = 1'b1;
        #1;
        check_head("bp0", 1'b1, ef[0][0], ea[0], eb[0]);
        tick();
        chk("after_pop_fill", 8'(fill), 8'd3);
        chk("after_pop_src_ready", 8'(src_ready), 8'd1);
        check_head("bp1", 1'b1, ef[1][0], ea[1], eb[1]);
        tick();
        src_valid = 1'b0;
        chk("push_pop_fill", 8'(fill), 8'd3);
        for (int k = 2; k < 5; k++) begin
            check_head($sformatf("bp%0d", k), 1'b1, ef[k][0], ea[k], eb[k]);
            tick();
        end
        chk("bp_drain_fill", 8'(fill), 8'd0);
        chk("bp_drain_valid", 8'(net_valid), 8'd0);

        // Streaming: one packet every three cycles with the network always ready
        for (int p = 0; p < 3; p++) begin
            a = 8'(8'hA0 + p);
            w = mk(2'b00, a, ~a);
            for (int b = 0; b < 3; b++) begin
                src_valid = 1'b1;
                src = w[23-8*b -: 8];
                #1;
                chk("stream_src_ready", 8'(src_ready), 8'd1);
                tick();
                if (b == 2) begin
                    check_head($sformatf("stream%0d", p), 1'b1, 1'b0, a, ~a);
                    chk("stream_fill_one", 8'(fill), 8'd1);
                end else begin
                    chk("stream_fill_zero", 8'(fill), 8'd0);
                end
            end
        end
        src_valid = 1'b0;
        tick();
        chk("stream_end_fill", 8'(fill), 8'd0);

        // Reset mid-packet with one packet buffered
        net_ready = 1'b0;
        send_pkt(mk(2'b01, 8'h11, 8'h22));
        src_valid = 1'b1;
        src = 8'h12;
        tick();
        src = 8'h34;
        tick();
        src_valid = 1'b0;
        chk("pre_rst_fill", 8'(fill), 8'd1);
        arstn = 1'b0;
        #1;
        check_head("mid_rst", 1'b0, 1'b0, 8'h00, 8'h00);
        chk("mid_rst_fill", 8'(fill), 8'd0);
        chk("mid_rst_src_ready", 8'(src_ready), 8'd1);
        chk("mid_rst_net_arstn", 8'(net_arstn), 8'd0);
        tick();
        chk("mid_rst_net_arstn_hold", 8'(net_arstn), 8'd0);
        arstn = 1'b1;
        #1;
        chk("post_rst_net_arstn", 8'(net_arstn), 8'd1);
        chk("post_rst_fill", 8'(fill), 8'd0);
        send_pkt(mk(2'b00, 8'h5A, 8'hA5));
        #1;
        check_head("post_rst", 1'b1, 1'b0, 8'h5A, 8'hA5);
        chk("post_rst_pkt_fill", 8'(fill), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
